multi_ch_timer: RTL



---
 rtl/multi_ch_timer_pkg.sv | 39 +++
 rtl/multi_ch_timer_if.sv | 22 ++
 rtl/bcd_hms_counter.sv | 90 +++++++++
 rtl/multi_ch_timer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/multi_ch_timer_pkg.sv
// Shared constants and types for the multi-channel BCD hh:mm:ss timer.
// Opcodes, channel state encoding, BCD digit width/limits and a LOAD-value checker.
package multi_ch_timer_pkg;

  localparam int unsigned DigitW = 4;
  localparam int unsigned HmsW   = 6 * DigitW;
  localparam logic [DigitW-1:0] DigitMax = 4'd9;
  localparam logic [DigitW-1:0] TensMax  = 4'd5;

  typedef enum logic [1:0] {
    OpLoad  = 2'b00,
    OpStart = 2'b01,
    OpStop  = 2'b10,
    OpClear = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } ch_state_e;

  typedef struct packed {
    logic [DigitW-1:0] hour_m;
    logic [DigitW-1:0] hour_l;
    logic [DigitW-1:0] min_m;
    logic [DigitW-1:0] min_l;
    logic [DigitW-1:0] sec_m;
    logic [DigitW-1:0] sec_l;
  } hms_t;

  function automatic logic bcd_valid(input hms_t v, input int unsigned max_hour);
    return (v.hour_m <= DigitMax) && (v.hour_l <= DigitMax) &&
           (v.min_m <= TensMax) && (v.min_l <= DigitMax) &&
           (v.sec_m <= TensMax) && (v.sec_l <= DigitMax) &&
           ((32'(v.hour_m) * 32'd10 + 32'(v.hour_l)) <= max_hour);
  endfunction

endpackage

// File: rtl/multi_ch_timer_if.sv
// Command bus of the multi-channel timer: valid/ready strobe, opcode, payload and reject pulse.
interface multi_ch_timer_if;
  import multi_ch_timer_pkg::*;

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [2:0]        i_cmd_ch;
  logic [1:0]        i_cmd_op;
  logic              i_cmd_dir;
  logic [HmsW-1:0]   i_load_bcd;
  logic              o_cmd_err;

  modport master (
    output i_cmd_valid, i_cmd_ch, i_cmd_op, i_cmd_dir, i_load_bcd,
    input  o_cmd_ready, o_cmd_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_ch, i_cmd_op, i_cmd_dir, i_load_bcd,
    output o_cmd_ready, o_cmd_err
  );
endinterface

// File: rtl/bcd_hms_counter.sv
// One channel's hh:mm:ss BCD value: load, clear, and one-second up/down step with carry/borrow.
// Hours run 0..MAX_HOUR; zero/terminal flags tell the owner when a step will expire or wrap.
module bcd_hms_counter
  import multi_ch_timer_pkg::*;
#(
  parameter int unsigned MAX_HOUR = 99
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  hms_t load_val_i,
  input  logic load_dir_i,
  input  logic step_i,
  output hms_t value_o,
  output logic dir_o,
  output logic zero_o,
  output logic terminal_o
);

  localparam logic [DigitW-1:0] HourMaxM = DigitW'(MAX_HOUR / 10);
  localparam logic [DigitW-1:0] HourMaxL = DigitW'(MAX_HOUR % 10);
  localparam hms_t UpTerm = '{hour_m: HourMaxM, hour_l: HourMaxL, min_m: TensMax,
                              min_l: DigitMax, sec_m: TensMax, sec_l: DigitMax};
  localparam hms_t DownTerm = '{hour_m: '0, hour_l: '0, min_m: '0, min_l: '0, sec_m: '0,
                                sec_l: 4'd1};

  hms_t value_q, value_d;
  logic dir_q, up;
  logic c_sec_l, c_sec_m, c_min_l, c_min_m, hour_lim;

  function automatic logic at_edge(input logic [DigitW-1:0] d, input logic up_dir,
                                   input logic [DigitW-1:0] top);
    return up_dir ? (d == top) : (d == '0);
  endfunction

  function automatic logic [DigitW-1:0] roll(input logic [DigitW-1:0] d, input logic up_dir,
                                             input logic [DigitW-1:0] top);
    if (at_edge(d, up_dir, top)) return up_dir ? '0 : top;
    return up_dir ? d + DigitW'(1) : d - DigitW'(1);
  endfunction

  assign up = ~dir_q;

  // Each c_* means every lower digit wraps on this step, so the next digit moves.
  always_comb begin
    c_sec_l  = at_edge(value_q.sec_l, up, DigitMax);
    c_sec_m  = c_sec_l & at_edge(value_q.sec_m, up, TensMax);
    c_min_l  = c_sec_m & at_edge(value_q.min_l, up, DigitMax);
    c_min_m  = c_min_l & at_edge(value_q.min_m, up, TensMax);
    hour_lim = up ? ({value_q.hour_m, value_q.hour_l} == {HourMaxM, HourMaxL})
                  : ({value_q.hour_m, value_q.hour_l} == '0);
    value_d       = value_q;
    value_d.sec_l = roll(value_q.sec_l, up, DigitMax);
    if (c_sec_l) value_d.sec_m = roll(value_q.sec_m, up, TensMax);
    if (c_sec_m) value_d.min_l = roll(value_q.min_l, up, DigitMax);
    if (c_min_l) value_d.min_m = roll(value_q.min_m, up, TensMax);
    if (c_min_m) begin
      if (hour_lim) begin
        value_d.hour_m = up ? '0 : HourMaxM;
        value_d.hour_l = up ? '0 : HourMaxL;
      end else begin
        value_d.hour_l = roll(value_q.hour_l, up, DigitMax);
        if (at_edge(value_q.hour_l, up, DigitMax)) begin
          value_d.hour_m = roll(value_q.hour_m, up, DigitMax);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
      dir_q   <= 1'b0;
    end else if (clear_i) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
      dir_q   <= load_dir_i;
    end else if (step_i) begin
      value_q <= value_d;
    end
  end

  assign value_o    = value_q;
  assign dir_o      = dir_q;
  assign zero_o     = (value_q == '0);
  assign terminal_o = up ? (value_q == UpTerm) : (value_q == DownTerm);

endmodule

// File: rtl/multi_ch_timer.sv
// Multi-channel stopwatch/countdown timer: shared 1 s prescaler, command decode, BCD readback.
// Optional macro TIMER_LAP_EN adds a per-channel lap register and the i_rd_lap select input.
module multi_ch_timer
  import multi_ch_timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned MAX_HOUR = 99
) (
  input  logic               i_clk_dig,
  input  logic               i_rst,
  multi_ch_timer_if.slave    cmd,
  input  logic [2:0]         i_rd_ch,
`ifdef TIMER_LAP_EN
  input  logic               i_rd_lap,
`endif
  output logic [3:0]         o_sec_l,
  output logic [3:0]         o_sec_m,
  output logic [3:0]         o_min_l,
  output logic [3:0]         o_min_m,
  output logic [3:0]         o_hour_l,
  output logic [3:0]         o_hour_m,
  output logic [NUM_CH-1:0]  o_running,
  output logic [NUM_CH-1:0]  o_expired,
  output logic               o_tick
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PreW-1:0]   pre_q;
  logic              tick_q, err_q;
  logic              accept, ch_ok, load_ok, sel_zero_down, reject, cmd_go;
  cmd_op_e           op;
  hms_t              load_val, rd_val;
  hms_t              ch_val [NUM_CH];
  logic [NUM_CH-1:0] ch_dir, ch_zero, ch_term, run_vec, exp_vec;
`ifdef TIMER_LAP_EN
  hms_t              ch_lap [NUM_CH];
`endif

  always_ff @(posedge i_clk_dig) begin
    if (i_rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else if (pre_q == PreW'(TICK_DIV - 1)) begin
      pre_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      pre_q  <= pre_q + PreW'(1);
      tick_q <= 1'b0;
    end
  end

  assign op       = cmd_op_e'(cmd.i_cmd_op);
  assign load_val = cmd.i_load_bcd;
  assign accept   = cmd.i_cmd_valid & cmd.o_cmd_ready;
  assign ch_ok    = 32'(cmd.i_cmd_ch) < NUM_CH;
  assign load_ok  = bcd_valid(load_val, MAX_HOUR);

  always_comb begin
    sel_zero_down = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd.i_cmd_ch == 3'(i)) sel_zero_down = ch_dir[i] & ch_zero[i];
    end
  end

  assign reject = accept & (~ch_ok | ((op == OpLoad) & ~load_ok) |
                            ((op == OpStart) & sel_zero_down));
  assign cmd_go = accept & ~reject;

  always_ff @(posedge i_clk_dig) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= reject;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e st_q;
    logic      run_q, exp_q, hit, step, expire;

    // A command to this channel swallows a coincident tick.
    assign hit    = cmd_go & (cmd.i_cmd_ch == 3'(g));
    assign expire = tick_q & (st_q == StRun) & ~hit & ch_dir[g] & (ch_zero[g] | ch_term[g]);
    assign step   = tick_q & (st_q == StRun) & ~hit & ~(ch_dir[g] & ch_zero[g]);

    bcd_hms_counter #(
      .MAX_HOUR(MAX_HOUR)
    ) u_cnt (
      .clk_i      (i_clk_dig),
      .rst_i      (i_rst),
      .clear_i    (hit & (op == OpClear)),
      .load_i     (hit & (op == OpLoad)),
      .load_val_i (load_val),
      .load_dir_i (cmd.i_cmd_dir),
      .step_i     (step),
      .value_o    (ch_val[g]),
      .dir_o      (ch_dir[g]),
      .zero_o     (ch_zero[g]),
      .terminal_o (ch_term[g])
    );

    always_ff @(posedge i_clk_dig) begin
      if (i_rst) begin
        st_q  <= StIdle;
        run_q <= 1'b0;
        exp_q <= 1'b0;
      end else if (hit) begin
        unique case (op)
          OpLoad: begin
            if (st_q == StDone) st_q <= StIdle;
            exp_q <= 1'b0;
          end
          OpStart: begin
            if (st_q == StIdle) begin
              st_q  <= StRun;
              run_q <= 1'b1;
            end
          end
          OpStop: begin
            if (st_q == StRun) begin
              st_q  <= StIdle;
              run_q <= 1'b0;
            end
          end
          OpClear: begin
            st_q  <= StIdle;
            run_q <= 1'b0;
            exp_q <= 1'b0;
          end
        endcase
      end else if (expire) begin
        st_q  <= StDone;
        run_q <= 1'b0;
        exp_q <= 1'b1;
      end
    end

`ifdef TIMER_LAP_EN
    hms_t lap_q;
    always_ff @(posedge i_clk_dig) begin
      if (i_rst)                                          lap_q <= '0;
      else if (hit && op == OpClear)                      lap_q <= '0;
      else if (hit && op == OpStop && st_q == StIdle)     lap_q <= ch_val[g];
    end
    assign ch_lap[g] = lap_q;
`endif

    assign run_vec[g] = run_q;
    assign exp_vec[g] = exp_q;
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_rd_ch == 3'(i)) begin
`ifdef TIMER_LAP_EN
        rd_val = i_rd_lap ? ch_lap[i] : ch_val[i];
`else
        rd_val = ch_val[i];
`endif
      end
    end
    if (i_rst) rd_val = '0;
  end

  assign o_sec_l  = rd_val.sec_l;
  assign o_sec_m  = rd_val.sec_m;
  assign o_min_l  = rd_val.min_l;
  assign o_min_m  = rd_val.min_m;
  assign o_hour_l = rd_val.hour_l;
  assign o_hour_m = rd_val.hour_m;

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign o_running       = run_vec & {NUM_CH{~i_rst}};
  assign o_expired       = exp_vec & {NUM_CH{~i_rst}};
  assign o_tick          = tick_q & ~i_rst;
  assign cmd.o_cmd_err   = err_q & ~i_rst;
  assign cmd.o_cmd_ready = ~i_rst;

endmodule
